// File: rtl/reg_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Holds width defaults, the hard-wired zero register index, the round-robin
// pointer encoding and the request payload type.
// Optional feature macro: REG_WR_ARB_BYPASS_EN (see reg_wr_arbiter.sv).
package reg_wr_arbiter_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;

    // Register 0 is hard-wired; writes to it are dropped by the register file.
    localparam int unsigned ZERO_REG = 0;

    // Which requester wins the next contended cycle.
    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_state_t;

    // Writeback request payload at default widths.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Bundle of the writeback requester ports, register-file write port and
// read-hazard ports of reg_wr_arbiter.
//   master: requesters / read stage (drives valid/addr/data and read addresses)
//   slave : arbiter (drives readies, write port, hazards, optional bypass)
// With REG_WR_ARB_BYPASS_EN defined, byp_s1/s2 valid/data are added.
interface reg_wr_arbiter_if
    import reg_wr_arbiter_pkg::*;
#(
    parameter int unsigned data_width    = DATA_WIDTH,
    parameter int unsigned address_width = ADDR_WIDTH
) ();

    logic                     req0_valid;
    logic                     req0_ready;
    logic [address_width-1:0] req0_addr;
    logic [data_width-1:0]    req0_data;
    logic                     req1_valid;
    logic                     req1_ready;
    logic [address_width-1:0] req1_addr;
    logic [data_width-1:0]    req1_data;
    logic                     write_enable;
    logic [address_width-1:0] address_d;
    logic [data_width-1:0]    data_dval;
    logic [address_width-1:0] rd_addr_s1;
    logic [address_width-1:0] rd_addr_s2;
    logic                     hazard_s1;
    logic                     hazard_s2;
`ifdef REG_WR_ARB_BYPASS_EN
    logic                     byp_s1_valid;
    logic                     byp_s2_valid;
    logic [data_width-1:0]    byp_s1_data;
    logic [data_width-1:0]    byp_s2_data;
`endif

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output rd_addr_s1, rd_addr_s2,
        input  req0_ready, req1_ready,
        input  write_enable, address_d, data_dval,
        input  hazard_s1, hazard_s2
`ifdef REG_WR_ARB_BYPASS_EN
        , input byp_s1_valid, byp_s2_valid, byp_s1_data, byp_s2_data
`endif
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  rd_addr_s1, rd_addr_s2,
        output req0_ready, req1_ready,
        output write_enable, address_d, data_dval,
        output hazard_s1, hazard_s2
`ifdef REG_WR_ARB_BYPASS_EN
        , output byp_s1_valid, byp_s2_valid, byp_s1_data, byp_s2_data
`endif
    );

endinterface

// File: rtl/reg_wr_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clock, reset : clock and synchronous active-high reset
//   req[1:0]     : requests (held-entry valid bits)
//   grant[1:0]   : combinational one-hot grant
// The pointer only moves on contention, so a lone requester always wins.
module rr_arb2
    import reg_wr_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    rr_state_t state_q;
    rr_state_t state_d;

    // Pointer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RR_REQ0;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant and pointer update; on contention the favoured side wins and
    // the pointer flips to the other side.
    always_comb begin
        state_d = state_q;
        grant   = req;
        if (&req) begin
            if (state_q == RR_REQ1) begin
                grant   = 2'b10;
                state_d = RR_REQ0;
            end else begin
                grant   = 2'b01;
                state_d = RR_REQ1;
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Register-file write-port arbiter for two writeback requesters.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : req0/req1 valid/ready/addr/data, registered write port
//                  write_enable/address_d/data_dval, read addresses
//                  rd_addr_s1/s2 with combinational hazard_s1/s2
// Each requester owns a one-entry hold; rr_arb2 picks between valid holds and
// the winner is loaded into the registered write port.
// Optional macro REG_WR_ARB_BYPASS_EN: a read that only matches the write
// port is forwarded on byp_sX_valid/byp_sX_data instead of raising a hazard.
module reg_wr_arbiter
    import reg_wr_arbiter_pkg::*;
#(
    parameter int unsigned data_width    = DATA_WIDTH,
    parameter int unsigned address_width = ADDR_WIDTH
) (
    input logic             clock,
    input logic             reset,
    reg_wr_arbiter_if.slave bus
);

    logic [1:0]               hold_valid;
    logic [address_width-1:0] hold_addr [2];
    logic [data_width-1:0]    hold_data [2];
    logic [1:0]               grant;
    logic [1:0]               ready;
    logic [1:0]               accept;

    logic                     we_q;
    logic [address_width-1:0] addr_q;
    logic [data_width-1:0]    data_q;

    // A hold can take a new request when empty or when it drains this cycle.
    assign ready  = ~hold_valid | grant;
    assign accept = {bus.req1_valid, bus.req0_valid} & ready;

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];

    rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   (hold_valid),
        .grant (grant)
    );

    // Holding registers; a same-cycle accept wins over the grant clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid   <= '0;
            hold_addr[0] <= '0;
            hold_addr[1] <= '0;
            hold_data[0] <= '0;
            hold_data[1] <= '0;
        end else begin
            if (accept[0]) begin
                hold_valid[0] <= 1'b1;
                hold_addr[0]  <= bus.req0_addr;
                hold_data[0]  <= bus.req0_data;
            end else if (grant[0]) begin
                hold_valid[0] <= 1'b0;
            end
            if (accept[1]) begin
                hold_valid[1] <= 1'b1;
                hold_addr[1]  <= bus.req1_addr;
                hold_data[1]  <= bus.req1_data;
            end else if (grant[1]) begin
                hold_valid[1] <= 1'b0;
            end
        end
    end

    // Registered write port; address/data keep their last value when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= |grant;
            if (grant[1]) begin
                addr_q <= hold_addr[1];
                data_q <= hold_data[1];
            end else if (grant[0]) begin
                addr_q <= hold_addr[0];
                data_q <= hold_data[0];
            end
        end
    end

    assign bus.write_enable = we_q;
    assign bus.address_d    = addr_q;
    assign bus.data_dval    = data_q;

    // Read-address match against uncommitted writes; register 0 never hazards.
    logic s1_nz, s1_hold, s1_out;
    logic s2_nz, s2_hold, s2_out;

    assign s1_nz   = bus.rd_addr_s1 != address_width'(ZERO_REG);
    assign s1_hold = (hold_valid[0] && (hold_addr[0] == bus.rd_addr_s1)) ||
                     (hold_valid[1] && (hold_addr[1] == bus.rd_addr_s1));
    assign s1_out  = we_q && (addr_q == bus.rd_addr_s1);

    assign s2_nz   = bus.rd_addr_s2 != address_width'(ZERO_REG);
    assign s2_hold = (hold_valid[0] && (hold_addr[0] == bus.rd_addr_s2)) ||
                     (hold_valid[1] && (hold_addr[1] == bus.rd_addr_s2));
    assign s2_out  = we_q && (addr_q == bus.rd_addr_s2);

`ifdef REG_WR_ARB_BYPASS_EN
    // Forward from the write port only when no older-in-flight hold matches.
    assign bus.hazard_s1    = s1_nz & s1_hold;
    assign bus.byp_s1_valid = s1_nz & s1_out & ~s1_hold;
    assign bus.byp_s1_data  = data_q;
    assign bus.hazard_s2    = s2_nz & s2_hold;
    assign bus.byp_s2_valid = s2_nz & s2_out & ~s2_hold;
    assign bus.byp_s2_data  = data_q;
`else
    assign bus.hazard_s1 = s1_nz & (s1_hold | s1_out);
    assign bus.hazard_s2 = s2_nz & (s2_hold | s2_out);
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios plus random
// traffic, checked against a behavioural model and a write-port scoreboard.
module tb_reg_wr_arbiter;
    import reg_wr_arbiter_pkg::*;

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    reg_wr_arbiter_if #(.data_width(DW), .address_width(AW)) bus ();

    reg_wr_arbiter #(.data_width(DW), .address_width(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int n_cmp = 0;
    int n_bad = 0;

    wr_t     exp_q[$];
    wr_req_t src0[$];
    wr_req_t src1[$];
    int      log_q[$];
    bit      log_on  = 1'b0;
    bit      model_on = 1'b0;
    bit      started = 1'b0;

    // Reference state: pending (accepted, not yet written) entry per requester,
    // which requester is favoured on a tie, and the visible write port.
    bit            m_pend [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    int            m_favour = 0;
    wr_t           m_out = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pend_match(input logic [AW-1:0] rd);
        return (m_pend[0] && m_addr[0] == rd) || (m_pend[1] && m_addr[1] == rd);
    endfunction

    task automatic check_read(input string tag, input logic [AW-1:0] rd, input logic haz
`ifdef REG_WR_ARB_BYPASS_EN
                              , input logic bv, input logic [DW-1:0] bd
`endif
                              );
        bit nz, inh, ino;
        nz  = (rd != 0);
        inh = pend_match(rd);
        ino = m_out.we && (m_out.a == rd);
`ifdef REG_WR_ARB_BYPASS_EN
        chk({"hazard_", tag}, 64'(haz), 64'(nz && inh));
        chk({"byp_valid_", tag}, 64'(bv), 64'(nz && ino && !inh));
        if (nz && ino && !inh) chk({"byp_data_", tag}, 64'(bd), 64'(m_out.d));
`else
        chk({"hazard_", tag}, 64'(haz), 64'(nz && (inh || ino)));
`endif
    endtask

    // One model cycle: check combinational outputs, then advance to the next edge.
    task automatic model_step();
        bit g [2];
        bit rdy [2];
        if (m_pend[0] && m_pend[1]) begin
            g[0] = (m_favour == 0);
            g[1] = (m_favour == 1);
        end else begin
            g[0] = m_pend[0];
            g[1] = m_pend[1];
        end
        rdy[0] = !m_pend[0] || g[0];
        rdy[1] = !m_pend[1] || g[1];
        chk("req0_ready", 64'(bus.req0_ready), 64'(rdy[0]));
        chk("req1_ready", 64'(bus.req1_ready), 64'(rdy[1]));
`ifdef REG_WR_ARB_BYPASS_EN
        check_read("s1", bus.rd_addr_s1, bus.hazard_s1, bus.byp_s1_valid, bus.byp_s1_data);
        check_read("s2", bus.rd_addr_s2, bus.hazard_s2, bus.byp_s2_valid, bus.byp_s2_data);
`else
        check_read("s1", bus.rd_addr_s1, bus.hazard_s1);
        check_read("s2", bus.rd_addr_s2, bus.hazard_s2);
`endif
        if (reset) begin
            m_pend[0] = 1'b0;
            m_pend[1] = 1'b0;
            m_favour  = 0;
            m_out     = '0;
        end else begin
            if (g[0])      m_out = '{we: 1'b1, a: m_addr[0], d: m_data[0]};
            else if (g[1]) m_out = '{we: 1'b1, a: m_addr[1], d: m_data[1]};
            else           m_out.we = 1'b0;
            if (m_pend[0] && m_pend[1]) m_favour = 1 - m_favour;
            if (g[0]) m_pend[0] = 1'b0;
            if (g[1]) m_pend[1] = 1'b0;
            if (bus.req0_valid && rdy[0]) begin
                m_pend[0] = 1'b1;
                m_addr[0] = bus.req0_addr;
                m_data[0] = bus.req0_data;
            end
            if (bus.req1_valid && rdy[1]) begin
                m_pend[1] = 1'b1;
                m_addr[1] = bus.req1_addr;
                m_data[1] = bus.req1_data;
            end
        end
        exp_q.push_back(m_out);
        started = 1'b1;
    endtask

    always @(negedge clock) if (model_on) model_step();

    // Monitor: the write port after each edge must equal the model's prediction.
    initial begin
        wr_t e;
        forever begin
            @(posedge clock);
            #2;
            if (started) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_empty: got none want entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_enable", 64'(bus.write_enable), 64'(e.we));
                    chk("address_d", 64'(bus.address_d), 64'(e.a));
                    chk("data_dval", 64'(bus.data_dval), 64'(e.d));
                    if (log_on && bus.write_enable === 1'b1) log_q.push_back(int'(bus.address_d));
                end
            end
        end
    end

    task automatic drive(input bit rnd);
        bus.req0_valid = (src0.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
        bus.req1_valid = (src1.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
        bus.req0_addr  = (src0.size() > 0) ? src0[0].addr : AW'($urandom_range(0, 31));
        bus.req0_data  = (src0.size() > 0) ? src0[0].data : DW'($urandom);
        bus.req1_addr  = (src1.size() > 0) ? src1[0].addr : AW'($urandom_range(0, 31));
        bus.req1_data  = (src1.size() > 0) ? src1[0].data : DW'($urandom);
        if (rnd) begin
            bus.rd_addr_s1 = AW'($urandom_range(0, 7));
            bus.rd_addr_s2 = AW'($urandom_range(0, 7));
        end
    endtask

    // One cycle of stimulus; a source entry retires once it has been accepted.
    task automatic step(input bit rnd);
        bit a0, a1;
        @(negedge clock);
        a0 = !reset && bus.req0_valid && bus.req0_ready;
        a1 = !reset && bus.req1_valid && bus.req1_ready;
        @(posedge clock);
        #1;
        if (a0 && src0.size() > 0) void'(src0.pop_front());
        if (a1 && src1.size() > 0) void'(src1.pop_front());
        drive(rnd);
    endtask

    task automatic do_reset(input int n);
        src0.delete();
        src1.delete();
        reset          = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = AW'(9);
        bus.req0_data  = 32'h1234_5678;
        bus.req1_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
        reset          = 1'b0;
        bus.req0_valid = 1'b0;
    endtask

    task automatic check_log(input string name, input int exp_a[], input int n);
        chk({name, "_count"}, 64'(log_q.size()), 64'(n));
        for (int i = 0; i < n && i < log_q.size(); i++)
            chk($sformatf("%s_%0d", name, i), 64'(log_q[i]), 64'(exp_a[i]));
        log_q.delete();
    endtask

    initial begin
        int exp_c[];
        reset          = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = AW'(9);
        bus.req0_data  = 32'h1234_5678;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        bus.rd_addr_s1 = '0;
        bus.rd_addr_s2 = '0;
        @(posedge clock);
        #1;
        model_on = 1'b1;
        do_reset(2);

        // Single write.
        log_on = 1'b1;
        bus.rd_addr_s1 = AW'(5);
        src0.push_back('{addr: AW'(5), data: 32'hDEAD_BEEF});
        repeat (5) step(0);
        exp_c = '{5};
        check_log("single", exp_c, 1);

        // Contention: strict alternation starting with req0.
        do_reset(1);
        log_q.delete();
        for (int i = 1; i <= 4; i++) begin
            src0.push_back('{addr: AW'(i), data: DW'(32'h100 + i)});
            src1.push_back('{addr: AW'(10 + i), data: DW'(32'h200 + i)});
        end
        repeat (14) step(0);
        exp_c = '{1, 11, 2, 12, 3, 13, 4, 14};
        check_log("contend", exp_c, 8);

        // Back-to-back stream from req1.
        for (int i = 7; i <= 9; i++) src1.push_back('{addr: AW'(i), data: DW'($urandom)});
        repeat (6) step(0);
        exp_c = '{7, 8, 9};
        check_log("stream", exp_c, 3);

        // Hazard on a held address; write to register 0 never hazards.
        bus.rd_addr_s1 = AW'(3);
        bus.rd_addr_s2 = AW'(0);
        src0.push_back('{addr: AW'(3), data: 32'hCAFE_0003});
        src1.push_back('{addr: AW'(0), data: 32'hCAFE_0000});
        repeat (5) step(0);
        log_q.delete();
        log_on = 1'b0;

        // Reset while both holds and the write port are busy.
        bus.rd_addr_s1 = AW'(20);
        bus.rd_addr_s2 = AW'(21);
        for (int i = 0; i < 3; i++) begin
            src0.push_back('{addr: AW'(20 + i), data: DW'($urandom)});
            src1.push_back('{addr: AW'(21 + i), data: DW'($urandom)});
        end
        repeat (3) step(0);
        do_reset(1);
        repeat (4) step(0);

        // Random traffic.
        repeat (400) begin
            if (src0.size() < 2 && $urandom_range(0, 1) == 1)
                src0.push_back('{addr: AW'($urandom_range(0, 7)), data: DW'($urandom)});
            if (src1.size() < 2 && $urandom_range(0, 1) == 1)
                src1.push_back('{addr: AW'($urandom_range(0, 7)), data: DW'($urandom)});
            step(1);
        end

        // Drain within a bounded budget; nothing may be left unaccepted.
        for (int i = 0; i < 50 && (src0.size() > 0 || src1.size() > 0); i++) step(0);
        chk("drain_src0", 64'(src0.size()), 64'(0));
        chk("drain_src1", 64'(src1.size()), 64'(0));
        repeat (4) step(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
